// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants, tap indices and FSM encoding
// for the 3x3 window generator (CNN_EDGE_REPLICATE_EN aware).
package cnn_pkg;

  localparam int CNN_WIDTH = 18;
  localparam int NUM_TAPS  = 9;

  localparam int TAP_NW = 0;
  localparam int TAP_N  = 1;
  localparam int TAP_NE = 2;
  localparam int TAP_W  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_E  = 5;
  localparam int TAP_SW = 6;
  localparam int TAP_S  = 7;
  localparam int TAP_SE = 8;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } cnn_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_tap_select.sv
// cnn_tap_select: border handling for 9 raw taps.
// Zero padding by default; CNN_EDGE_REPLICATE_EN clamps to edge.
module cnn_tap_select
  import cnn_pkg::*;
#(
  parameter int WIDTH = CNN_WIDTH,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  localparam int RW = cnt_w(IMG_H),
  localparam int CW = cnt_w(IMG_W)
) (
  input  logic [NUM_TAPS*WIDTH-1:0] raw,
  input  logic [RW-1:0]             row,
  input  logic [CW-1:0]             col,
  output logic [NUM_TAPS*WIDTH-1:0] taps
);

  logic at_top, at_bot, at_lft, at_rgt;

  assign at_top = (row == '0);
  assign at_bot = (row == RW'(IMG_H-1));
  assign at_lft = (col == '0);
  assign at_rgt = (col == CW'(IMG_W-1));

`ifdef CNN_EDGE_REPLICATE_EN
  logic [WIDTH-1:0] raw_a [NUM_TAPS];
  for (genvar j = 0; j < NUM_TAPS; j++) begin : g_raw
    assign raw_a[j] = raw[j*WIDTH +: WIDTH];
  end
`endif

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    localparam int DR = k / 3;
    localparam int DC = k % 3;
    logic row_out, col_out;
    assign row_out = ((DR == 0) && at_top)
                  || ((DR == 2) && at_bot);
    assign col_out = ((DC == 0) && at_lft)
                  || ((DC == 2) && at_rgt);
`ifdef CNN_EDGE_REPLICATE_EN
    // an outside neighbour collapses onto the centre row/col
    logic [3:0] sel;
    assign sel = 4'((row_out ? 1 : DR) * 3
                  + (col_out ? 1 : DC));
    assign taps[k*WIDTH +: WIDTH] = raw_a[sel];
`else
    assign taps[k*WIDTH +: WIDTH] =
      (row_out || col_out) ? '0 : raw[k*WIDTH +: WIDTH];
`endif
  end

endmodule

// File: rtl/cnn_window_gen.sv
// cnn_window_gen: raster pixel stream to one 3x3 window per pixel.
// Border mode selected by CNN_EDGE_REPLICATE_EN (zero pad if undefined).
module cnn_window_gen
  import cnn_pkg::*;
#(
  parameter int WIDTH = CNN_WIDTH,
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  localparam int RW = cnt_w(IMG_H),
  localparam int CW = cnt_w(IMG_W)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_TAPS*WIDTH-1:0] win,
  output logic [RW-1:0]             out_row,
  output logic [CW-1:0]             out_col,
  output logic                      out_last
);

  localparam int DEPTH = 2*IMG_W + 3;
  localparam int TOT   = IMG_W * IMG_H;
  localparam int PW    = cnt_w(TOT);
  localparam int FW    = cnt_w(IMG_W + 2);

  cnn_state_e state;

  logic [PW-1:0] pix_cnt;
  logic [FW-1:0] fl_cnt;
  logic [RW-1:0] er;
  logic [CW-1:0] ec;

  // the oldest slot only exists as sr_nxt; it is never read back
  logic [WIDTH-1:0] sr     [DEPTH-1];
  logic [WIDTH-1:0] sr_nxt [DEPTH];

  logic free, fl_done, at_end;
  logic acc, flush_go, adv, load;
  logic [NUM_TAPS*WIDTH-1:0] raw, taps;

  assign free    = !out_valid || out_ready;
  assign fl_done = (fl_cnt == FW'(IMG_W+1));
  assign at_end  = (er == RW'(IMG_H-1))
                && (ec == CW'(IMG_W-1));

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      unique case (state)
        ST_FILL:   in_ready = 1'b1;
        ST_STREAM: in_ready = free;
        default:   in_ready = 1'b0;
      endcase
    end
  end

  assign acc      = in_valid && in_ready;
  assign flush_go = (state == ST_FLUSH)
                 && !fl_done && free;
  assign adv      = acc || flush_go;
  assign load     = ((state == ST_STREAM) && acc)
                 || flush_go;

  always_comb begin
    sr_nxt[0] = (state == ST_FLUSH) ? '0 : in_data;
    for (int i = 1; i < DEPTH; i++)
      sr_nxt[i] = sr[i-1];
  end

  assign raw[TAP_NW*WIDTH +: WIDTH] = sr_nxt[2*IMG_W+2];
  assign raw[TAP_N *WIDTH +: WIDTH] = sr_nxt[2*IMG_W+1];
  assign raw[TAP_NE*WIDTH +: WIDTH] = sr_nxt[2*IMG_W];
  assign raw[TAP_W *WIDTH +: WIDTH] = sr_nxt[IMG_W+2];
  assign raw[TAP_C *WIDTH +: WIDTH] = sr_nxt[IMG_W+1];
  assign raw[TAP_E *WIDTH +: WIDTH] = sr_nxt[IMG_W];
  assign raw[TAP_SW*WIDTH +: WIDTH] = sr_nxt[2];
  assign raw[TAP_S *WIDTH +: WIDTH] = sr_nxt[1];
  assign raw[TAP_SE*WIDTH +: WIDTH] = sr_nxt[0];

  cnn_tap_select #(
    .WIDTH (WIDTH),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_sel (
    .raw  (raw),
    .row  (er),
    .col  (ec),
    .taps (taps)
  );

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int i = 0; i < DEPTH-1; i++)
        sr[i] <= sr_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FILL;
      pix_cnt   <= '0;
      fl_cnt    <= '0;
      er        <= '0;
      ec        <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      win       <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      if (load) begin
        win       <= taps;
        out_row   <= er;
        out_col   <= ec;
        out_last  <= at_end;
        out_valid <= 1'b1;
        if (ec == CW'(IMG_W-1)) begin
          ec <= '0;
          er <= at_end ? '0 : er + 1'b1;
        end else begin
          ec <= ec + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        ST_FILL: begin
          if (acc) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_cnt == PW'(IMG_W))
              state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (acc) begin
            if (pix_cnt == PW'(TOT-1)) begin
              pix_cnt <= '0;
              state   <= ST_FLUSH;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_go)
            fl_cnt <= fl_cnt + 1'b1;
          if (fl_done && out_valid && out_ready) begin
            fl_cnt <= '0;
            state  <= ST_FILL;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_window_gen.sv
// tb_cnn_window_gen: random/directed frames vs an index-based
// window model; honours CNN_EDGE_REPLICATE_EN.
module tb_cnn_window_gen;

  localparam int WIDTH = 18;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int TOT   = IMG_W * IMG_H;
  localparam int WW    = 9 * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WW-1:0]    win;
  logic [1:0]       out_row;
  logic [1:0]       out_col;
  logic             out_last;

  cnn_window_gen #(
    .WIDTH (WIDTH),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .win       (win),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [WW-1:0] got,
                       input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [WW-1:0] w;
    int            r;
    int            c;
    bit            last;
  } exp_t;

  exp_t             exp_q [$];
  logic [WIDTH-1:0] img [IMG_H][IMG_W];

  function automatic logic [WW-1:0] ref_win(input int r,
                                            input int c);
    logic [WW-1:0] v = '0;
    int rr, cc;
    for (int k = 0; k < 9; k++) begin
      rr = r + k / 3 - 1;
      cc = c + k % 3 - 1;
`ifdef CNN_EDGE_REPLICATE_EN
      rr = (rr < 0) ? 0 : ((rr > IMG_H-1) ? IMG_H-1 : rr);
      cc = (cc < 0) ? 0 : ((cc > IMG_W-1) ? IMG_W-1 : cc);
      v[k*WIDTH +: WIDTH] = img[rr][cc];
`else
      if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W)
        v[k*WIDTH +: WIDTH] = img[rr][cc];
`endif
    end
    return v;
  endfunction

  function automatic logic [WW-1:0] win00_const();
`ifdef CNN_EDGE_REPLICATE_EN
    int t[9] = '{1, 1, 2, 1, 1, 2, 5, 5, 6};
`else
    int t[9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
`endif
    logic [WW-1:0] v = '0;
    for (int k = 0; k < 9; k++)
      v[k*WIDTH +: WIDTH] = WIDTH'(t[k]);
    return v;
  endfunction

  task automatic load_frame(input bit seq);
    exp_t e;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = seq ? WIDTH'(r*IMG_W + c + 1)
                        : WIDTH'($urandom);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        e.w    = ref_win(r, c);
        e.r    = r;
        e.c    = c;
        e.last = (r == IMG_H-1) && (c == IMG_W-1);
        exp_q.push_back(e);
      end
  endtask

  int stall   = 0;
  bit rnd_rdy = 0;

  always @(posedge clk) begin
    #1;
    if (stall > 0) begin
      out_ready = 1'b0;
      stall--;
    end else begin
      out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0)
                          : 1'b1;
    end
  end

  bit            held = 0;
  logic [WW-1:0] h_w;
  logic [3:0]    h_pos;
  exp_t          m;

  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else begin
      if (held) begin
        check("hold_valid", WW'(out_valid), WW'(1));
        check("hold_win", win, h_w);
        check("hold_pos", WW'({out_row, out_col}), WW'(h_pos));
      end
      if (out_valid && !out_ready)
        check("bp_in_ready", WW'(in_ready), WW'(0));
      if (out_valid && out_ready) begin
        check("win_avail", WW'(exp_q.size() != 0), WW'(1));
        if (exp_q.size() != 0) begin
          m = exp_q.pop_front();
          check("win", win, m.w);
          check("row", WW'(out_row), WW'(m.r));
          check("col", WW'(out_col), WW'(m.c));
          check("last", WW'(out_last), WW'(m.last));
        end
      end
      held  = out_valid && !out_ready;
      h_w   = win;
      h_pos = {out_row, out_col};
    end
  end

  task automatic drive_pixel(input logic [WIDTH-1:0] d,
                             input bit gaps);
    bit acc = 0;
    int n   = 0;
    if (gaps)
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc)
      check("accept_timeout", WW'(acc), WW'(1));
  endtask

  task automatic send_frame(input bit seq, input bit gaps,
                            input bit lat, input bit bp,
                            input int stop_at);
    load_frame(seq);
    for (int k = 0; k < TOT; k++) begin
      if (k == stop_at)
        return;
      drive_pixel(img[k / IMG_W][k % IMG_W], gaps);
      if (lat && k == IMG_W)
        check("fill_no_out", WW'(out_valid), WW'(0));
      if (lat && k == IMG_W + 1) begin
        check("lat_valid", WW'(out_valid), WW'(1));
        check("lat_pos", WW'({out_row, out_col}), WW'(0));
        check("lat_win", win, win00_const());
      end
      if (bp && k == 8)
        stall = 3;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", WW'(exp_q.size()), WW'(0));
  endtask

  task automatic chk_reset();
    check("rst_ctl",
          WW'({in_ready, out_valid, out_last, out_row, out_col}),
          WW'(0));
    check("rst_win", win, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b0;

    send_frame(1, 0, 1, 0, -1);
    wait_drain();

    send_frame(1, 0, 0, 1, -1);
    wait_drain();

    send_frame(1, 0, 0, 0, 7);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk_reset();
    rst = 1'b0;
    send_frame(1, 0, 1, 0, -1);
    wait_drain();

    rnd_rdy = 1;
    repeat (6) send_frame(0, 1, 0, 0, -1);
    wait_drain();

    rnd_rdy = 0;
    repeat (2) send_frame(0, 0, 0, 0, -1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
